// File: rtl/pdp11_pkg.sv
// Shared types and helpers for the PDP-11 operand-fetch slice: addressing
// modes, fetch FSM states, SP/PC indices and the auto-inc/dec step size.
package pdp11_pkg;

  typedef enum logic [2:0] {
    REG         = 3'd0,
    REG_DEF     = 3'd1,
    AUTOINC     = 3'd2,
    AUTOINC_DEF = 3'd3,
    AUTODEC     = 3'd4,
    AUTODEC_DEF = 3'd5,
    INDEX       = 3'd6,
    INDEX_DEF   = 3'd7
  } addr_mode_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IDX_FETCH  = 3'd1,
    PTR_FETCH  = 3'd2,
    DATA_FETCH = 3'd3,
    DONE       = 3'd4
  } opfetch_state_t;

  localparam int NREGS_DEFAULT = 8;
  localparam int SP_IDX        = NREGS_DEFAULT - 2;
  localparam int PC_IDX        = NREGS_DEFAULT - 1;

  // SP and PC always step by a full word so they stay even on byte ops.
  function automatic logic [1:0] inc_size(input logic is_byte, input int reg_idx,
                                          input int nregs);
    return (is_byte && (reg_idx != nregs - 2) && (reg_idx != nregs - 1)) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/pdp11_ea_calc.sv
// Combinational address arithmetic for one operand specifier: register side
// effect, first memory address, index sum and odd-address detection.
module pdp11_ea_calc
  import pdp11_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8
) (
  input  addr_mode_t                mode_i,
  input  logic [$clog2(NREGS)-1:0]  reg_i,
  input  logic                      byte_i,
  input  logic [WORD_W-1:0]         r_i,
  input  logic [WORD_W-1:0]         x_i,
  output logic                      wr_o,
  output logic [WORD_W-1:0]         nreg_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [ADDR_W-1:0]         idx_sum_o,
  output logic                      odd_o
);

  logic [ADDR_W-1:0] r_a;
  logic [ADDR_W-1:0] inc_a;
  logic [ADDR_W-1:0] two_a;
  logic [ADDR_W-1:0] dec_a;

  assign r_a       = ADDR_W'(r_i);
  assign inc_a     = ADDR_W'(inc_size(byte_i, int'(reg_i), NREGS));
  assign two_a     = ADDR_W'(2);
  assign idx_sum_o = ADDR_W'(x_i) + r_a;

  // Data modes fault only on odd word accesses; pointer/index fetches are
  // always word reads, so any odd address there is a fault.
  always_comb begin
    wr_o   = 1'b0;
    nreg_o = r_i;
    addr_o = r_a;
    odd_o  = 1'b0;
    dec_a  = '0;
    unique case (mode_i)
      REG: begin
      end
      REG_DEF: odd_o = !byte_i && r_a[0];
      AUTOINC: begin
        wr_o   = 1'b1;
        nreg_o = WORD_W'(r_a + inc_a);
        odd_o  = !byte_i && r_a[0];
      end
      AUTOINC_DEF: begin
        wr_o   = 1'b1;
        nreg_o = WORD_W'(r_a + two_a);
        odd_o  = r_a[0];
      end
      AUTODEC: begin
        dec_a  = r_a - inc_a;
        wr_o   = 1'b1;
        nreg_o = WORD_W'(dec_a);
        addr_o = dec_a;
        odd_o  = !byte_i && dec_a[0];
      end
      AUTODEC_DEF: begin
        dec_a  = r_a - two_a;
        wr_o   = 1'b1;
        nreg_o = WORD_W'(dec_a);
        addr_o = dec_a;
        odd_o  = dec_a[0];
      end
      INDEX, INDEX_DEF: begin
        wr_o   = 1'b1;
        nreg_o = WORD_W'(r_a + two_a);
        odd_o  = r_a[0];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/pdp11_operand_fetch.sv
// PDP-11 operand fetch: resolves one (mode, reg) specifier through the register
// file and a single-outstanding memory port. Define OPFETCH_ODD_ADDR_TRAP_EN to
// turn odd word addresses into op_fault instead of silently forcing bit0 low.
module pdp11_operand_fetch
  import pdp11_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_mode,
  input  logic [$clog2(NREGS)-1:0]  req_reg,
  input  logic                      req_byte,
  output logic [$clog2(NREGS)-1:0]  rf_rd_addr,
  input  logic [WORD_W-1:0]         rf_rd_data,
  output logic                      rf_wr_en,
  output logic [$clog2(NREGS)-1:0]  rf_wr_addr,
  output logic [WORD_W-1:0]         rf_wr_data,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [WORD_W-1:0]         op_data,
  output logic [ADDR_W-1:0]         op_addr,
  output logic                      op_is_reg,
  output logic                      op_fault
);

  localparam int RW = $clog2(NREGS);
  localparam logic [RW-1:0] PcIdx = RW'(NREGS - 1);

`ifdef OPFETCH_ODD_ADDR_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] even_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

  function automatic logic [ADDR_W-1:0] data_ea(input logic is_byte, input logic [ADDR_W-1:0] a);
    return is_byte ? a : even_addr(a);
  endfunction

  opfetch_state_t    state_q;
  addr_mode_t        mode_q;
  logic [RW-1:0]     reg_q;
  logic              byte_q;
  logic [ADDR_W-1:0] ea_q;
  logic              req_ready_q;
  logic              rf_wr_en_q;
  logic [RW-1:0]     rf_wr_addr_q;
  logic [WORD_W-1:0] rf_wr_data_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              op_valid_q;
  logic [WORD_W-1:0] op_data_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic              op_is_reg_q;
  logic              op_fault_q;

  addr_mode_t        req_mode_e;
  logic              is_idle;
  logic              acked;
  addr_mode_t        calc_mode;
  logic [RW-1:0]     calc_reg;
  logic              calc_byte;
  logic [WORD_W-1:0] calc_r;
  logic              c_wr;
  logic [WORD_W-1:0] c_nreg;
  logic [ADDR_W-1:0] c_addr;
  logic [ADDR_W-1:0] c_sum;
  logic              c_odd;
  logic              idx_odd;
  logic [ADDR_W-1:0] ptr;

  assign req_mode_e = addr_mode_t'(req_mode);
  assign is_idle    = (state_q == IDLE);
  assign acked      = mem_req_q && mem_ack;

  // Index modes read PC first; the base register is read later in IDX_FETCH.
  assign rf_rd_addr = is_idle ? (((req_mode_e == INDEX) || (req_mode_e == INDEX_DEF)) ? PcIdx : req_reg)
                              : reg_q;

  // With a zero-wait index fetch the PC write has not landed in the register
  // file yet, so PC-relative sums take the incremented value held locally.
  assign calc_mode = is_idle ? req_mode_e : mode_q;
  assign calc_reg  = is_idle ? req_reg : reg_q;
  assign calc_byte = is_idle ? req_byte : byte_q;
  assign calc_r    = (!is_idle && (reg_q == PcIdx)) ? rf_wr_data_q : rf_rd_data;

  pdp11_ea_calc #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_ea_calc (
    .mode_i    (calc_mode),
    .reg_i     (calc_reg),
    .byte_i    (calc_byte),
    .r_i       (calc_r),
    .x_i       (mem_rdata),
    .wr_o      (c_wr),
    .nreg_o    (c_nreg),
    .addr_o    (c_addr),
    .idx_sum_o (c_sum),
    .odd_o     (c_odd)
  );

  assign idx_odd = (mode_q == INDEX) ? (!byte_q && c_sum[0]) : c_sum[0];
  assign ptr     = ADDR_W'(mem_rdata);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mode_q       <= REG;
      reg_q        <= '0;
      byte_q       <= 1'b0;
      ea_q         <= '0;
      req_ready_q  <= 1'b1;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      op_valid_q   <= 1'b0;
      op_data_q    <= '0;
      op_addr_q    <= '0;
      op_is_reg_q  <= 1'b0;
      op_fault_q   <= 1'b0;
    end else begin
      rf_wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            mode_q      <= req_mode_e;
            reg_q       <= req_reg;
            byte_q      <= req_byte;
            req_ready_q <= 1'b0;
            op_is_reg_q <= 1'b0;
            op_fault_q  <= 1'b0;
            if (req_mode_e == REG) begin
              op_data_q   <= rf_rd_data;
              op_addr_q   <= ADDR_W'(req_reg);
              op_is_reg_q <= 1'b1;
              op_valid_q  <= 1'b1;
              state_q     <= DONE;
            end else begin
              if (c_wr) begin
                rf_wr_en_q   <= 1'b1;
                rf_wr_addr_q <= rf_rd_addr;
                rf_wr_data_q <= c_nreg;
              end
              ea_q <= data_ea(req_byte, c_addr);
              if (TrapEn && c_odd) begin
                op_data_q  <= '0;
                op_addr_q  <= c_addr;
                op_fault_q <= 1'b1;
                op_valid_q <= 1'b1;
                state_q    <= DONE;
              end else begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= even_addr(c_addr);
                unique case (req_mode_e)
                  REG_DEF, AUTOINC, AUTODEC: state_q <= DATA_FETCH;
                  AUTOINC_DEF, AUTODEC_DEF:  state_q <= PTR_FETCH;
                  default:                   state_q <= IDX_FETCH;
                endcase
              end
            end
          end
        end
        IDX_FETCH: begin
          if (acked) begin
            ea_q <= (mode_q == INDEX) ? data_ea(byte_q, c_sum) : c_sum;
            if (TrapEn && idx_odd) begin
              mem_req_q  <= 1'b0;
              op_data_q  <= '0;
              op_addr_q  <= c_sum;
              op_fault_q <= 1'b1;
              op_valid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              mem_addr_q <= even_addr(c_sum);
              state_q    <= (mode_q == INDEX) ? DATA_FETCH : PTR_FETCH;
            end
          end
        end
        PTR_FETCH: begin
          if (acked) begin
            ea_q <= data_ea(byte_q, ptr);
            if (TrapEn && !byte_q && ptr[0]) begin
              mem_req_q  <= 1'b0;
              op_data_q  <= '0;
              op_addr_q  <= ptr;
              op_fault_q <= 1'b1;
              op_valid_q <= 1'b1;
              state_q    <= DONE;
            end else begin
              mem_addr_q <= even_addr(ptr);
              state_q    <= DATA_FETCH;
            end
          end
        end
        DATA_FETCH: begin
          if (acked) begin
            mem_req_q <= 1'b0;
            if (byte_q) begin
              op_data_q <= ea_q[0] ? WORD_W'(mem_rdata[15:8]) : WORD_W'(mem_rdata[7:0]);
            end else begin
              op_data_q <= mem_rdata;
            end
            op_addr_q  <= ea_q;
            op_valid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (op_ready) begin
            op_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign op_valid   = op_valid_q;
  assign op_data    = op_data_q;
  assign op_addr    = op_addr_q;
  assign op_is_reg  = op_is_reg_q;
  assign op_fault   = TrapEn & op_fault_q;

endmodule

// File: tb/tb_pdp11_operand_fetch.sv
// Directed bench for pdp11_operand_fetch with a combinational register-file
// model and a word memory with programmable wait states.
module tb_pdp11_operand_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_mode = 3'd0;
  logic [2:0]  req_reg = 3'd0;
  logic        req_byte = 1'b0;
  logic [2:0]  rf_rd_addr;
  logic [15:0] rf_rd_data;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [15:0] op_data;
  logic [15:0] op_addr;
  logic        op_is_reg;
  logic        op_fault;

  logic [15:0] rf [0:7];
  logic [15:0] mem [0:32767];
  int          wait_n = 0;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic        pre_en = 1'b0;
  logic [2:0]  pre_idx = 3'd0;
  logic [15:0] pre_val = 16'h0;
  logic [15:0] acc_log [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  pdp11_operand_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_reg    (req_reg),
    .req_byte   (req_byte),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_data    (op_data),
    .op_addr    (op_addr),
    .op_is_reg  (op_is_reg),
    .op_fault   (op_fault)
  );

  assign rf_rd_data = rf[rf_rd_addr];
  assign mem_ack    = mem_req && (wcnt >= wait_n);
  assign mem_rdata  = mem[mem_addr[15:1]];

  always @(posedge clk) begin
    if (rf_wr_en) begin
      rf[rf_wr_addr] <= rf_wr_data;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_en) begin
      rf[pre_idx] <= pre_val;
    end
    if (mem_req && !mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (mem_req && mem_ack) acc_log.push_back(mem_addr);
  end

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [15:0] v);
    mem[a[15:1]] = v;
  endtask

  task automatic run_op(input logic [2:0] m, input logic [2:0] r, input logic b, output int lat);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_before_issue got=%b exp=1", req_ready); end
    req_mode = m; req_reg = r; req_byte = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (op_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL op_valid_timeout mode=%0d got=%b exp=1", m, op_valid); end
  endtask

  task automatic release_op();
    @(negedge clk);
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL rst_op_valid got=%b exp=0", op_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL rst_rf_wr_en got=%b exp=0", rf_wr_en); end
    total++; if ({op_data, op_addr, mem_addr} !== 48'h0) begin bad++; $display("FAIL rst_zero_outputs got=%h exp=0", {op_data, op_addr, mem_addr}); end
    total++; if (op_fault !== 1'b0) begin bad++; $display("FAIL rst_op_fault got=%b exp=0", op_fault); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_mode0();
    int lat; int n0; int w0;
    set_reg(3'd3, 16'h1234);
    n0 = acc_log.size(); w0 = wr_cnt;
    run_op(3'd0, 3'd3, 1'b0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL m0_latency got=%0d exp=1", lat); end
    total++; if (op_data !== 16'h1234) begin bad++; $display("FAIL m0_data got=%h exp=1234", op_data); end
    total++; if (op_is_reg !== 1'b1) begin bad++; $display("FAIL m0_is_reg got=%b exp=1", op_is_reg); end
    total++; if (op_addr !== 16'h0003) begin bad++; $display("FAIL m0_addr got=%h exp=0003", op_addr); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL m0_req_ready_busy got=%b exp=0", req_ready); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (op_valid !== 1'b1 || op_data !== 16'h1234) begin bad++; $display("FAIL m0_hold got=%b/%h exp=1/1234", op_valid, op_data); end
    total++; if (acc_log.size() !== n0) begin bad++; $display("FAIL m0_no_mem got=%0d exp=%0d", acc_log.size(), n0); end
    total++; if (wr_cnt !== w0) begin bad++; $display("FAIL m0_no_write got=%0d exp=%0d", wr_cnt, w0); end
    release_op();
    total++; if (op_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL m0_release got=%b/%b exp=0/1", op_valid, req_ready); end
  endtask

  task automatic test_autoinc_byte();
    int lat; int n0;
    set_reg(3'd1, 16'h0101);
    set_mem(16'h0100, 16'hAB12);
    n0 = acc_log.size();
    run_op(3'd2, 3'd1, 1'b1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL m2b_latency got=%0d exp=2", lat); end
    total++; if (acc_log[n0] !== 16'h0100) begin bad++; $display("FAIL m2b_mem_addr got=%h exp=0100", acc_log[n0]); end
    total++; if (rf[1] !== 16'h0102) begin bad++; $display("FAIL m2b_r1 got=%h exp=0102", rf[1]); end
    total++; if (op_data !== 16'h00AB) begin bad++; $display("FAIL m2b_data got=%h exp=00ab", op_data); end
    total++; if (op_addr !== 16'h0101 || op_is_reg !== 1'b0) begin bad++; $display("FAIL m2b_addr got=%h/%b exp=0101/0", op_addr, op_is_reg); end
    release_op();
  endtask

  task automatic test_immediate();
    int lat;
    set_reg(3'd7, 16'h0200);
    set_mem(16'h0200, 16'h0042);
    run_op(3'd2, 3'd7, 1'b0, lat);
    total++; if (op_data !== 16'h0042) begin bad++; $display("FAIL imm_data got=%h exp=0042", op_data); end
    total++; if (rf[7] !== 16'h0202) begin bad++; $display("FAIL imm_pc got=%h exp=0202", rf[7]); end
    release_op();
    set_reg(3'd7, 16'h0200);
    run_op(3'd2, 3'd7, 1'b1, lat);
    total++; if (rf[7] !== 16'h0202) begin bad++; $display("FAIL imm_byte_pc got=%h exp=0202", rf[7]); end
    total++; if (op_data !== 16'h0042) begin bad++; $display("FAIL imm_byte_data got=%h exp=0042", op_data); end
    release_op();
  endtask

  task automatic test_deferred_modes();
    int lat; int n0;
    set_reg(3'd5, 16'h0500);
    set_mem(16'h0500, 16'h0600);
    set_mem(16'h0600, 16'hBEEF);
    run_op(3'd3, 3'd5, 1'b0, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL m3_latency got=%0d exp=3", lat); end
    total++; if (op_data !== 16'hBEEF || op_addr !== 16'h0600) begin bad++; $display("FAIL m3_result got=%h/%h exp=beef/0600", op_data, op_addr); end
    total++; if (rf[5] !== 16'h0502) begin bad++; $display("FAIL m3_r5 got=%h exp=0502", rf[5]); end
    release_op();
    run_op(3'd5, 3'd5, 1'b0, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL m5_latency got=%0d exp=3", lat); end
    total++; if (rf[5] !== 16'h0500) begin bad++; $display("FAIL m5_r5 got=%h exp=0500", rf[5]); end
    total++; if (op_data !== 16'hBEEF || op_addr !== 16'h0600) begin bad++; $display("FAIL m5_result got=%h/%h exp=beef/0600", op_data, op_addr); end
    release_op();
    set_reg(3'd7, 16'h0700);
    set_mem(16'h0700, 16'h0004);
    set_mem(16'h1238, 16'h4321);
    n0 = acc_log.size();
    run_op(3'd6, 3'd3, 1'b0, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL m6_latency got=%0d exp=3", lat); end
    total++; if (op_data !== 16'h4321 || op_addr !== 16'h1238) begin bad++; $display("FAIL m6_result got=%h/%h exp=4321/1238", op_data, op_addr); end
    total++; if (rf[7] !== 16'h0702 || acc_log[n0] !== 16'h0700) begin bad++; $display("FAIL m6_pc got=%h/%h exp=0702/0700", rf[7], acc_log[n0]); end
    release_op();
    set_reg(3'd7, 16'h0800);
    set_mem(16'h0800, 16'h0010);
    set_mem(16'h0812, 16'h9999);
    run_op(3'd6, 3'd7, 1'b0, lat);
    total++; if (op_data !== 16'h9999 || op_addr !== 16'h0812) begin bad++; $display("FAIL m6_pcrel got=%h/%h exp=9999/0812", op_data, op_addr); end
    release_op();
  endtask

  task automatic test_index_def_wait();
    int lat; int n0;
    set_reg(3'd2, 16'h1000);
    set_reg(3'd7, 16'h0300);
    set_mem(16'h0300, 16'h0010);
    set_mem(16'h1010, 16'h2000);
    set_mem(16'h2000, 16'h5555);
    wait_n = 2;
    n0 = acc_log.size();
    run_op(3'd7, 3'd2, 1'b0, lat);
    total++; if (lat !== 10) begin bad++; $display("FAIL m7_latency got=%0d exp=10", lat); end
    total++; if (rf[7] !== 16'h0302) begin bad++; $display("FAIL m7_pc got=%h exp=0302", rf[7]); end
    total++; if (op_addr !== 16'h2000 || op_data !== 16'h5555) begin bad++; $display("FAIL m7_result got=%h/%h exp=2000/5555", op_addr, op_data); end
    total++; if (acc_log[n0] !== 16'h0300 || acc_log[n0+1] !== 16'h1010 || acc_log[n0+2] !== 16'h2000) begin
      bad++; $display("FAIL m7_access_seq got=%h,%h,%h exp=0300,1010,2000", acc_log[n0], acc_log[n0+1], acc_log[n0+2]);
    end
    wait_n = 0;
    release_op();
  endtask

  task automatic test_autodec_wrap_reset();
    int lat; int n0; int w0;
    set_reg(3'd6, 16'h0000);
    set_mem(16'hFFFE, 16'h7777);
    n0 = acc_log.size();
    run_op(3'd4, 3'd6, 1'b1, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL m4_latency got=%0d exp=2", lat); end
    total++; if (rf[6] !== 16'hFFFE || acc_log[n0] !== 16'hFFFE) begin bad++; $display("FAIL m4_wrap got=%h/%h exp=fffe/fffe", rf[6], acc_log[n0]); end
    total++; if (op_data !== 16'h0077 || op_addr !== 16'hFFFE) begin bad++; $display("FAIL m4_result got=%h/%h exp=0077/fffe", op_data, op_addr); end
    release_op();
    set_reg(3'd6, 16'h0010);
    set_mem(16'h0010, 16'h3333);
    wait_n = 5;
    w0 = wr_cnt;
    @(negedge clk);
    req_mode = 3'd1; req_reg = 3'd6; req_byte = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin bad++; $display("FAIL rmid_req got=%b/%h exp=1/0010", mem_req, mem_addr); end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || op_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_abort got=%b/%b/%b exp=1/0/0", req_ready, mem_req, op_valid);
    end
    wait_n = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (op_valid !== 1'b0 || req_ready !== 1'b1 || wr_cnt !== w0) begin
      bad++; $display("FAIL rmid_idle got=%b/%b/%0d exp=0/1/%0d", op_valid, req_ready, wr_cnt, w0);
    end
    run_op(3'd1, 3'd6, 1'b0, lat);
    total++; if (lat !== 2 || op_data !== 16'h3333) begin bad++; $display("FAIL rmid_next got=%0d/%h exp=2/3333", lat, op_data); end
    release_op();
  endtask

  task automatic test_back_to_back();
    int lat;
    set_reg(3'd4, 16'h0400);
    set_mem(16'h0400, 16'h1111);
    set_mem(16'h0402, 16'h2222);
    run_op(3'd2, 3'd4, 1'b0, lat);
    total++; if (op_data !== 16'h1111) begin bad++; $display("FAIL b2b_first got=%h exp=1111", op_data); end
    release_op();
    run_op(3'd2, 3'd4, 1'b0, lat);
    total++; if (op_data !== 16'h2222 || op_addr !== 16'h0402) begin bad++; $display("FAIL b2b_second got=%h/%h exp=2222/0402", op_data, op_addr); end
    total++; if (rf[4] !== 16'h0404) begin bad++; $display("FAIL b2b_r4 got=%h exp=0404", rf[4]); end
    release_op();
  endtask

  task automatic test_odd_addr();
    int lat; int n0;
    set_reg(3'd0, 16'h0101);
    n0 = acc_log.size();
    run_op(3'd1, 3'd0, 1'b0, lat);
`ifdef OPFETCH_ODD_ADDR_TRAP_EN
    total++; if (op_fault !== 1'b1) begin bad++; $display("FAIL odd_fault got=%b exp=1", op_fault); end
    total++; if (acc_log.size() !== n0) begin bad++; $display("FAIL odd_no_mem got=%0d exp=%0d", acc_log.size(), n0); end
    total++; if (op_data !== 16'h0000 || lat !== 1) begin bad++; $display("FAIL odd_data got=%h/%0d exp=0000/1", op_data, lat); end
`else
    total++; if (op_fault !== 1'b0) begin bad++; $display("FAIL odd_fault got=%b exp=0", op_fault); end
    total++; if (acc_log[n0] !== 16'h0100) begin bad++; $display("FAIL odd_mem_addr got=%h exp=0100", acc_log[n0]); end
    total++; if (op_data !== 16'hAB12 || op_addr !== 16'h0100) begin bad++; $display("FAIL odd_result got=%h/%h exp=ab12/0100", op_data, op_addr); end
`endif
    release_op();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_autoinc_byte();
    test_immediate();
    test_deferred_modes();
    test_index_def_wait();
    test_autodec_wrap_reset();
    test_back_to_back();
    test_odd_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
